sd_desc_fetch: RTL and testbench
================================

Name: sd_desc_fetch

Overview:
- Initiator/reader for the storage-descriptor memory (sd_memory-style responder with fixed 2-cycle read latency).
- Accepts a start storage-descriptor pointer and issues sequential reads. Collects returned entries (icntl, op, options, dcntl) into a small FIFO and streams them to the WU consumer with valid/ready flow control.
- Stops at the end-of-descriptor marker in dcntl.

Parameters:
- ADDR_W, 10, descriptor memory address width.
- OPT_PER_INST, 2, option fields per entry.
- OPT_TYPE_W, 8, option type width.
- OPT_VALUE_W, 16, option value width.
- CNTL_W, 2, std-intf cntl width.
- INST_W, 2, op field width.
- FIFO_DEPTH, 4, entry buffer depth (power of 2, ≥3).
- MAX_DESC_LEN, 16, entry count guard per descriptor.

Ports:
- clk  in  1  clock.
- reset_poweron  in  1  synchronous, active-high reset.
- xx1__sdf__valid  in  1  fetch request.
- xx1__sdf__stor_desc_ptr  in  ADDR_W  start pointer.
- sdf__xx1__ready  out  1  request can be accepted.
- sdf__xx1__done  out  1  one-cycle pulse when the last entry is popped.
- sdf__xx1__err  out  1  sticky length-guard error.
- sdf__sdm__read  out  1  memory read strobe.
- sdf__sdm__stor_desc_ptr  out  ADDR_W  read address.
- sdm__sdf__valid  in  1  response valid.
- sdm__sdf__icntl  in  CNTL_W  instruction delineator.
- sdm__sdf__dcntl  in  CNTL_W  descriptor delineator.
- sdm__sdf__op  in  INST_W  op.
- sdm__sdf__option_type  in  OPT_PER_INST*OPT_TYPE_W  packed, option 0 in LSBs.
- sdm__sdf__option_value  in  OPT_PER_INST*OPT_VALUE_W  packed, option 0 in LSBs.
- sdf__yy1__valid  out  1  entry available.
- yy1__sdf__ready  in  1  consumer accepts.
- sdf__yy1__icntl, sdf__yy1__dcntl, sdf__yy1__op, sdf__yy1__option_type, sdf__yy1__option_value  out  same widths  entry fields.

Behaviour:
- Clock and reset: single clock clk. reset_poweron is synchronous, active-high. On reset:
  - state=IDLE; FIFO empty; outstanding=0; entry count=0.
  - Outputs: ready=1, read=0, ptr=0, done=0, err=0, yy1 valid=0, yy1 data=0.
- dcntl encoding: SOM=2'b01, MOM=2'b00, EOM=2'b10, SOM_EOM=2'b11. End of descriptor = EOM or SOM_EOM.
- Request acceptance:
  - Request accepted when xx1__sdf__valid && sdf__xx1__ready.
  - ready is 1 only in IDLE.
  - On accept: ptr loads stor_desc_ptr, err clears, count clears, state moves to FETCH.
- FETCH state:
  - read=1 in any cycle where outstanding + fifo_count < FIFO_DEPTH.
  - Each read issues the current ptr. ptr increments after each issue and wraps from 2^ADDR_W-1 to 0.
  - The first read occurs the cycle after accept.
- Response capture:
  - Memory response arrives exactly 2 cycles after read; the block tolerates any latency.
  - Each sdm__sdf__valid decrements outstanding.
  - Responses are written to the FIFO only while end_seen=0.
  - Response with outstanding=0 is ignored.
- Simultaneous events: issue and response in the same cycle leave outstanding unchanged. Push and pop in the same cycle leave fifo_count unchanged.
- End of descriptor:
  - Writing an end-of-descriptor entry sets end_seen, stops reads, and moves state to DRAIN.
  - Later in-flight responses are discarded, never written.
- Length guard: if the written entry is the MAX_DESC_LEN-th and is not an end entry:
  - its stored dcntl is forced to EOM;
  - err is set (sticky until next accept);
  - it is treated as the end entry.
- DRAIN state: wait until outstanding==0 and FIFO empty, then go to IDLE. ready returns the cycle after the last pop.
- Output interface:
  - sdf__yy1__valid = FIFO non-empty.
  - Data is the FIFO head, first-word-fall-through.
  - Pop on valid&&ready.
  - Data is stable while valid && !ready.
  - Data is 0 when empty.
- done pulses in the cycle the popped entry is the end entry.
- FIFO full: never overflows, because issue is gated by the credit sum.
- Reset mid-operation: all state is cleared. Stale memory responses after reset are ignored because outstanding=0.
- Throughput: 1 entry/cycle sustained when consumer ready=1 and FIFO_DEPTH≥3.

Test Plan:
1. Memory holds entries 0x10..0x12 with dcntl SOM, MOM, EOM; request ptr=0x10; consumer always ready ->
   - reads issued at 0x10, 0x11, 0x12 and up to 0x13 (speculative);
   - 3 entries output in order;
   - done pulses with the 3rd pop; speculative response discarded;
   - ready=1 after drain.
2. Single entry with SOM_EOM at ptr=0x3FF ->
   - one entry output, done pulses;
   - ptr wrap read at 0x000 occurs and its response is discarded;
   - err=0.
3. 8-entry descriptor, consumer ready low for 10 cycles ->
   - reads stall at outstanding+count=4, no FIFO overflow;
   - head data held stable;
   - all 8 entries delivered in order after ready rises.
4. 20 MOM entries with no end marker ->
   - exactly 16 output, 16th with dcntl=EOM;
   - err=1 until the next accept; done pulses.
5. reset_poweron asserted in FETCH with 2 reads outstanding ->
   - next cycle: valid=0, ready=1, outstanding=0;
   - the 2 late responses are not output.
6. xx1__sdf__valid held high during an active fetch ->
   - second request accepted only the cycle after IDLE is re-entered;
   - both descriptors delivered with no interleaving.

Source files
------------

// File: rtl/sd_desc_fetch.sv
// sd_desc_fetch: storage-descriptor fetch engine.
// Reads descriptor entries sequentially from a fixed-latency responder,
// buffers them in a small first-word-fall-through FIFO and streams them to
// the WU consumer. Fetching stops at the end-of-descriptor entry, or at
// MAX_DESC_LEN entries, in which case the last entry is forced to EOM and a
// sticky error is raised.
module sd_desc_fetch #(
    parameter int ADDR_W       = 10,
    parameter int OPT_PER_INST = 2,
    parameter int OPT_TYPE_W   = 8,
    parameter int OPT_VALUE_W  = 16,
    parameter int CNTL_W       = 2,
    parameter int INST_W       = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_DESC_LEN = 16
) (
    input  logic                                clk,
    input  logic                                reset_poweron,
    input  logic                                xx1__sdf__valid,
    input  logic [ADDR_W-1:0]                   xx1__sdf__stor_desc_ptr,
    output logic                                sdf__xx1__ready,
    output logic                                sdf__xx1__done,
    output logic                                sdf__xx1__err,
    output logic                                sdf__sdm__read,
    output logic [ADDR_W-1:0]                   sdf__sdm__stor_desc_ptr,
    input  logic                                sdm__sdf__valid,
    input  logic [CNTL_W-1:0]                   sdm__sdf__icntl,
    input  logic [CNTL_W-1:0]                   sdm__sdf__dcntl,
    input  logic [INST_W-1:0]                   sdm__sdf__op,
    input  logic [OPT_PER_INST*OPT_TYPE_W-1:0]  sdm__sdf__option_type,
    input  logic [OPT_PER_INST*OPT_VALUE_W-1:0] sdm__sdf__option_value,
    output logic                                sdf__yy1__valid,
    input  logic                                yy1__sdf__ready,
    output logic [CNTL_W-1:0]                   sdf__yy1__icntl,
    output logic [CNTL_W-1:0]                   sdf__yy1__dcntl,
    output logic [INST_W-1:0]                   sdf__yy1__op,
    output logic [OPT_PER_INST*OPT_TYPE_W-1:0]  sdf__yy1__option_type,
    output logic [OPT_PER_INST*OPT_VALUE_W-1:0] sdf__yy1__option_value
);

    localparam int OT_W  = OPT_PER_INST * OPT_TYPE_W;
    localparam int OV_W  = OPT_PER_INST * OPT_VALUE_W;
    localparam int ENT_W = 2 * CNTL_W + INST_W + OT_W + OV_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LEN_W = $clog2(MAX_DESC_LEN + 1);

    localparam logic [CNTL_W-1:0] DC_EOM     = CNTL_W'(2);
    localparam logic [CNTL_W-1:0] DC_SOM_EOM = CNTL_W'(3);
    localparam logic [CNT_W:0]    DEPTH_L    = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [LEN_W-1:0]  LAST_IDX   = LEN_W'(MAX_DESC_LEN - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  ptr;
    logic [CNT_W-1:0]   outstanding, out_nx;
    logic [CNT_W-1:0]   fifo_cnt, cnt_nx;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LEN_W-1:0]   ent_cnt;
    logic               err;
    logic [ENT_W-1:0]   ent_q [FIFO_DEPTH];
    logic               end_q [FIFO_DEPTH];

    logic               accept, rsp_ok, push, pop, rsp_end, guard, push_end;
    logic               credit_ok, read;
    logic [CNTL_W-1:0]  push_dcntl;
    logic [ENT_W-1:0]   head;

    // Handshakes, credit gating and length guard
    always_comb begin
        accept     = (state == IDLE) && xx1__sdf__valid;
        rsp_ok     = sdm__sdf__valid && (outstanding != '0);
        push       = rsp_ok && (state == FETCH);
        rsp_end    = (sdm__sdf__dcntl == DC_EOM) || (sdm__sdf__dcntl == DC_SOM_EOM);
        guard      = (ent_cnt == LAST_IDX) && !rsp_end;
        push_end   = push && (rsp_end || guard);
        push_dcntl = guard ? DC_EOM : sdm__sdf__dcntl;
        credit_ok  = ({1'b0, outstanding} + {1'b0, fifo_cnt}) < DEPTH_L;
        // No further reads once the end entry is being written this cycle
        read       = (state == FETCH) && credit_ok && !push_end;
        pop        = (fifo_cnt != '0) && yy1__sdf__ready;
        out_nx     = outstanding + CNT_W'(read) - CNT_W'(rsp_ok);
        cnt_nx     = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    end

    // Next-state logic; DRAIN exits on next-cycle counts so ready returns right after the last pop
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = FETCH;
            FETCH:   if (push_end) state_nx = DRAIN;
            DRAIN:   if ((out_nx == '0) && (cnt_nx == '0)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control state, pointers, counters and sticky error
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state       <= IDLE;
            ptr         <= '0;
            outstanding <= '0;
            fifo_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ent_cnt     <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_nx;
            outstanding <= out_nx;
            fifo_cnt    <= cnt_nx;
            if (accept) begin
                ptr     <= xx1__sdf__stor_desc_ptr;
                ent_cnt <= '0;
                err     <= 1'b0;
            end else begin
                if (read) ptr <= ptr + ADDR_W'(1);
                if (push) ent_cnt <= ent_cnt + LEN_W'(1);
                if (push && guard) err <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            ent_q[wr_ptr] <= {sdm__sdf__icntl, push_dcntl, sdm__sdf__op,
                              sdm__sdf__option_type, sdm__sdf__option_value};
            end_q[wr_ptr] <= push_end;
        end
    end

    // Output mapping; head is forced to zero while empty
    always_comb begin
        head                    = (fifo_cnt != '0) ? ent_q[rd_ptr] : '0;
        sdf__yy1__valid         = (fifo_cnt != '0);
        sdf__xx1__ready         = (state == IDLE);
        sdf__xx1__done          = pop && end_q[rd_ptr];
        sdf__xx1__err           = err;
        sdf__sdm__read          = read;
        sdf__sdm__stor_desc_ptr = ptr;
        {sdf__yy1__icntl, sdf__yy1__dcntl, sdf__yy1__op,
         sdf__yy1__option_type, sdf__yy1__option_value} = head;
    end

endmodule

// File: tb/tb_sd_desc_fetch.sv
// Self-checking bench for sd_desc_fetch: a 2-cycle memory responder model,
// a monitor that checks every read address, output entry and done pulse
// against expected contents, and table-driven descriptor fetches plus
// hand-written reset and back-to-back request sequences.
module tb_sd_desc_fetch;

    logic        clk = 1'b0;
    logic        reset_poweron = 1'b1;
    logic        req_valid = 1'b0;
    logic [9:0]  req_ptr = '0;
    logic        sdf_ready, sdf_done, sdf_err, rd;
    logic [9:0]  rd_addr;
    logic        sdm_valid;
    logic [1:0]  sdm_icntl, sdm_dcntl, sdm_op;
    logic [15:0] sdm_ot;
    logic [31:0] sdm_ov;
    logic        yy_valid;
    logic        yy_ready = 1'b1;
    logic [1:0]  yy_icntl, yy_dcntl, yy_op;
    logic [15:0] yy_ot;
    logic [31:0] yy_ov;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    sd_desc_fetch #(
        .ADDR_W(10), .OPT_PER_INST(2), .OPT_TYPE_W(8), .OPT_VALUE_W(16),
        .CNTL_W(2), .INST_W(2), .FIFO_DEPTH(4), .MAX_DESC_LEN(16)
    ) dut (
        .clk(clk), .reset_poweron(reset_poweron),
        .xx1__sdf__valid(req_valid), .xx1__sdf__stor_desc_ptr(req_ptr),
        .sdf__xx1__ready(sdf_ready), .sdf__xx1__done(sdf_done), .sdf__xx1__err(sdf_err),
        .sdf__sdm__read(rd), .sdf__sdm__stor_desc_ptr(rd_addr),
        .sdm__sdf__valid(sdm_valid), .sdm__sdf__icntl(sdm_icntl), .sdm__sdf__dcntl(sdm_dcntl),
        .sdm__sdf__op(sdm_op), .sdm__sdf__option_type(sdm_ot), .sdm__sdf__option_value(sdm_ov),
        .sdf__yy1__valid(yy_valid), .yy1__sdf__ready(yy_ready),
        .sdf__yy1__icntl(yy_icntl), .sdf__yy1__dcntl(yy_dcntl), .sdf__yy1__op(yy_op),
        .sdf__yy1__option_type(yy_ot), .sdf__yy1__option_value(yy_ov)
    );

    // ---------------- memory model ----------------
    logic [1:0] mem_dc [1024];
    logic       p1_v = 1'b0, p2_v = 1'b0;
    logic [9:0] p1_a = '0, p2_a = '0;

    function automatic logic [1:0]  f_icntl(input logic [9:0] a); return a[1:0]; endfunction
    function automatic logic [1:0]  f_op(input logic [9:0] a);    return a[3:2]; endfunction
    function automatic logic [15:0] f_ot(input logic [9:0] a);    return {a[7:0] ^ 8'h5A, a[7:0]}; endfunction
    function automatic logic [31:0] f_ov(input logic [9:0] a);    return {a, 6'h2A, 6'h00, a}; endfunction

    always @(posedge clk) begin
        p1_v <= rd;
        p1_a <= rd_addr;
        p2_v <= p1_v;
        p2_a <= p1_a;
    end

    assign sdm_valid = p2_v;
    assign sdm_icntl = f_icntl(p2_a);
    assign sdm_dcntl = mem_dc[p2_a];
    assign sdm_op    = f_op(p2_a);
    assign sdm_ot    = f_ot(p2_a);
    assign sdm_ov    = f_ov(p2_a);

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic [9:0]  exp_ptr = '0, exp_raddr = '0;
    int unsigned exp_n = 0, pend_n = 0, got = 0, reads = 0, done_cnt = 0, accepts = 0;
    bit          exp_err = 0, pend_err = 0, busy = 0, after_done = 0;

    // Checks every read address, every output entry (including held head data
    // under backpressure), zero data while empty and exact done placement.
    always @(negedge clk) begin
        logic [9:0]  a;
        logic [1:0]  dc;
        logic [53:0] exp_e;
        bit          pop, exp_done;
        if (!reset_poweron) begin
            if (rd) begin
                check("read_addr", 64'(rd_addr), 64'(exp_raddr));
                exp_raddr = exp_raddr + 10'd1;
                reads++;
            end
            if (after_done) begin
                check("ready_after_last_pop", 64'(sdf_ready), 64'd1);
                after_done = 0;
            end
            if (yy_valid) begin
                a     = exp_ptr + 10'(got);
                dc    = (exp_err && got == exp_n - 1) ? 2'b10 : mem_dc[a];
                exp_e = {f_icntl(a), dc, f_op(a), f_ot(a), f_ov(a)};
                check("entry", 64'({yy_icntl, yy_dcntl, yy_op, yy_ot, yy_ov}), 64'(exp_e));
            end else begin
                check("empty_data_zero", 64'({yy_icntl, yy_dcntl, yy_op, yy_ot, yy_ov}), 64'd0);
            end
            pop      = yy_valid && yy_ready;
            exp_done = pop && (got == exp_n - 1);
            check("done", 64'(sdf_done), 64'(exp_done));
            if (pop) got++;
            if (exp_done) begin
                done_cnt++;
                busy       = 0;
                after_done = 1;
            end
            if (req_valid && sdf_ready) begin
                check("accept_when_idle", 64'(busy), 64'd0);
                busy      = 1;
                accepts++;
                exp_ptr   = req_ptr;
                exp_raddr = req_ptr;
                got       = 0;
                reads     = 0;
                exp_n     = pend_n;
                exp_err   = pend_err;
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [9:0]  ptr;
        int unsigned len;       // 0: no end marker at all
        int unsigned stall;     // consumer-not-ready cycles after accept
        int unsigned exp_n;
        bit          exp_err;
        int unsigned exp_reads; // 0: not checked
    } vec_t;

    vec_t vecs[7];
    bit   last_err = 0;

    task automatic setup_mem(input logic [9:0] ptr, input int unsigned len);
        logic [9:0] a;
        for (int unsigned i = 0; i < 24; i++) begin
            a = ptr + 10'(i);
            if (len == 0)            mem_dc[a] = 2'b00;
            else if (i >= len)       mem_dc[a] = 2'b01;
            else if (len == 1)       mem_dc[a] = 2'b11;
            else if (i == 0)         mem_dc[a] = 2'b01;
            else if (i == len - 1)   mem_dc[a] = 2'b10;
            else                     mem_dc[a] = 2'b00;
        end
    endtask

    task automatic wait_done(input int unsigned target);
        int unsigned c = 0;
        while (done_cnt < target && c < 400) begin
            @(posedge clk);
            c++;
        end
        check("done_pulses", 64'(done_cnt), 64'(target));
        repeat (2) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        int unsigned d0;
        setup_mem(v.ptr, v.len);
        check("err_sticky_before_accept", 64'(sdf_err), 64'(last_err));
        d0       = done_cnt;
        pend_n   = v.exp_n;
        pend_err = v.exp_err;
        yy_ready = (v.stall == 0);
        req_valid = 1'b1;
        req_ptr   = v.ptr;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("err_clear_on_accept", 64'(sdf_err), 64'd0);
        if (v.stall != 0) begin
            repeat (v.stall) @(negedge clk);
            check("stall_reads", 64'(reads), 64'd4);
            check("stall_valid", 64'(yy_valid), 64'd1);
            @(posedge clk);
            #1 yy_ready = 1'b1;
        end
        wait_done(d0 + 1);
        check("entry_count", 64'(got), 64'(v.exp_n));
        if (v.exp_reads != 0) check("read_count", 64'(reads), 64'(v.exp_reads));
        check("err", 64'(sdf_err), 64'(v.exp_err));
        check("ready_idle", 64'(sdf_ready), 64'd1);
        last_err = v.exp_err;
    endtask

    initial begin
        int unsigned d0, a0, c;
        vecs[0] = '{ptr: 10'h010, len: 3,  stall: 0,  exp_n: 3,  exp_err: 0, exp_reads: 4};
        vecs[1] = '{ptr: 10'h3FF, len: 1,  stall: 0,  exp_n: 1,  exp_err: 0, exp_reads: 2};
        vecs[2] = '{ptr: 10'h080, len: 8,  stall: 10, exp_n: 8,  exp_err: 0, exp_reads: 0};
        vecs[3] = '{ptr: 10'h040, len: 0,  stall: 0,  exp_n: 16, exp_err: 1, exp_reads: 17};
        vecs[4] = '{ptr: 10'h200, len: 5,  stall: 0,  exp_n: 5,  exp_err: 0, exp_reads: 6};
        vecs[5] = '{ptr: 10'h150, len: 16, stall: 0,  exp_n: 16, exp_err: 0, exp_reads: 17};
        vecs[6] = '{ptr: 10'h180, len: 2,  stall: 0,  exp_n: 2,  exp_err: 0, exp_reads: 3};
        for (int unsigned i = 0; i < 1024; i++) mem_dc[i] = 2'b00;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready", 64'(sdf_ready), 64'd1);
        check("rst_read",  64'(rd), 64'd0);
        check("rst_ptr",   64'(rd_addr), 64'd0);
        check("rst_done",  64'(sdf_done), 64'd0);
        check("rst_err",   64'(sdf_err), 64'd0);
        check("rst_valid", 64'(yy_valid), 64'd0);
        check("rst_data",  64'({yy_icntl, yy_dcntl, yy_op, yy_ot, yy_ov}), 64'd0);
        @(posedge clk);
        #1 reset_poweron = 1'b0;

        for (int unsigned i = 0; i < 6; i++) run_vec(vecs[i]);

        // reset with two reads outstanding; late responses must not surface
        setup_mem(10'h100, 8);
        pend_n = 99;
        pend_err = 0;
        req_valid = 1'b1;
        req_ptr   = 10'h100;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_poweron = 1'b1;
        @(posedge clk);
        #1 reset_poweron = 1'b0;
        busy = 0;
        @(negedge clk);
        check("mid_rst_valid", 64'(yy_valid), 64'd0);
        check("mid_rst_ready", 64'(sdf_ready), 64'd1);
        check("mid_rst_read",  64'(rd), 64'd0);
        repeat (6) @(negedge clk);
        check("stale_not_output", 64'(got), 64'd0);
        last_err = 0;
        run_vec(vecs[6]);

        // request held high across an active fetch
        setup_mem(10'h200, 3);
        setup_mem(10'h300, 2);
        d0 = done_cnt;
        a0 = accepts;
        pend_n = 3;
        pend_err = 0;
        req_valid = 1'b1;
        req_ptr   = 10'h200;
        @(posedge clk);
        #1 req_ptr = 10'h300;
        pend_n = 2;
        c = 0;
        while (accepts < a0 + 2 && c < 400) begin
            @(posedge clk);
            #1;
            c++;
        end
        req_valid = 1'b0;
        check("held_req_accepts", 64'(accepts), 64'(a0 + 2));
        wait_done(d0 + 2);
        check("held_req_second_count", 64'(got), 64'd2);
        check("held_req_ready", 64'(sdf_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
